// File: rtl/array_mult_pkg.sv
// Shared constants and the arithmetic reference for the carry-save array multiplier.
package array_mult_pkg;

    localparam int DEFAULT_N = 4;
    localparam int MAX_N     = 16;

    // Plain-arithmetic result of a*b + si + ci at full extended width.
    function automatic logic [2*MAX_N:0] ref_product(
        input logic [MAX_N-1:0] a,
        input logic [MAX_N-1:0] b,
        input logic             si,
        input logic             ci
    );
        logic [2*MAX_N:0] wide_a;
        logic [2*MAX_N:0] wide_b;
        wide_a = (2*MAX_N+1)'(a);
        wide_b = (2*MAX_N+1)'(b);
        return wide_a * wide_b + (2*MAX_N+1)'(si) + (2*MAX_N+1)'(ci);
    endfunction

endpackage

// File: rtl/mult_fa_cell.sv
// One full-adder cell of the multiplier array.
module mult_fa_cell (
    input  logic a,
    input  logic b,
    input  logic cin,
    output logic sum,
    output logic cout
);

    assign sum  = a ^ b ^ cin;
    assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/array_multiplier.sv
// Unsigned NxN carry-save array multiplier computing a*b + si + ci, result registered once.
module array_multiplier
    import array_mult_pkg::*;
#(
    parameter int N = DEFAULT_N
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [N-1:0]   a,
    input  logic [N-1:0]   b,
    input  logic           si,
    input  logic           ci,
    output logic [2*N-1:0] p,
    output logic           co
);

    logic [N-1:0]   pp [N];
    logic [2*N-1:0] prod;
    logic           carry;

    for (genvar i = 0; i < N; i++) begin : g_pp
        assign pp[i] = a & {N{b[i]}};
    end

    // Row 0 finalises bits 0 and 1 (cell 1 absorbs cell 0's carry); each later
    // carry-save row r finalises bit r+1, so the ripple row spans bits N..2N-1
    // and its last carry is a genuine bit 2N.
    for (genvar r = 0; r < N; r++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            logic x, y, z, s, c;

            if (r == 0) begin : g_x
                assign x = pp[0][j];
            end else if (r == 1 && j + 2 < N) begin : g_x
                assign x = g_row[0].g_col[j+2].s;
            end else if (r == 1 && j == N - 2) begin : g_x
                assign x = pp[1][N-1];
            end else if (r >= 2 && j < N - 1) begin : g_x
                assign x = g_row[r-1].g_col[j+1].s;
            end else begin : g_x
                assign x = 1'b0;
            end

            if (r == 0 && j == 0) begin : g_y
                assign y = si;
            end else if (r == 0) begin : g_y
                assign y = pp[1][j-1];
            end else if (r == 1 && j + 1 < N) begin : g_y
                assign y = g_row[0].g_col[j+1].c;
            end else if (r >= 2) begin : g_y
                assign y = g_row[r-1].g_col[j].c;
            end else begin : g_y
                assign y = 1'b0;
            end

            if (r == 0 && j == 0) begin : g_z
                assign z = ci;
            end else if (r == 0 && j == 1) begin : g_z
                assign z = g_row[0].g_col[0].c;
            end else if (r == 0) begin : g_z
                assign z = 1'b0;
            end else if (r == N - 1 && j == 0) begin : g_z
                assign z = 1'b0;
            end else if (r == N - 1) begin : g_z
                assign z = g_row[r].g_col[j-1].c;
            end else begin : g_z
                assign z = pp[r+1][j];
            end

            mult_fa_cell u_fa (
                .a    (x),
                .b    (y),
                .cin  (z),
                .sum  (s),
                .cout (c)
            );
        end
    end

    assign prod[0] = g_row[0].g_col[0].s;
    assign prod[1] = g_row[0].g_col[1].s;

    for (genvar r = 1; r < N - 1; r++) begin : g_low
        assign prod[r+1] = g_row[r].g_col[0].s;
    end

    for (genvar k = 0; k < N; k++) begin : g_high
        assign prod[N+k] = g_row[N-1].g_col[k].s;
    end

    assign carry = g_row[N-1].g_col[N-1].c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p  <= '0;
            co <= 1'b0;
        end else begin
            p  <= prod;
            co <= carry;
        end
    end

endmodule

// File: tb/tb_array_multiplier.sv
// Self-checking bench for array_multiplier: directed literals plus an arithmetic model checked every cycle.
module tb_array_multiplier;
    import array_mult_pkg::*;

    localparam int N = DEFAULT_N;

    logic           clk;
    logic           rst_n;
    logic [N-1:0]   a;
    logic [N-1:0]   b;
    logic           si;
    logic           ci;
    logic [2*N-1:0] p;
    logic           co;

    int check_count = 0;
    int pass_count  = 0;
    bit compare_on  = 1'b0;

    logic [2*N:0] model_result = '0;

    localparam int NUM_DIR = 11;
    localparam int DIR_A  [NUM_DIR] = '{5, 15, 5, 4, 13, 10, 3, 15, 0, 5, 15};
    localparam int DIR_B  [NUM_DIR] = '{10, 3, 2, 8, 14, 11, 10, 15, 0, 0, 15};
    localparam int DIR_SI [NUM_DIR] = '{0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1};
    localparam int DIR_CI [NUM_DIR] = '{0, 0, 0, 0, 1, 1, 1, 1, 1, 0, 1};
    localparam int DIR_P  [NUM_DIR] = '{50, 45, 10, 32, 183, 111, 31, 226, 2, 0, 227};

    localparam int NUM_SEQ = 4;
    localparam int SEQ_A  [NUM_SEQ] = '{3, 7, 15, 1};
    localparam int SEQ_B  [NUM_SEQ] = '{4, 9, 2, 1};
    localparam int SEQ_SI [NUM_SEQ] = '{0, 0, 0, 1};
    localparam int SEQ_P  [NUM_SEQ] = '{12, 63, 30, 2};

    array_multiplier #(.N(N)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .a     (a),
        .b     (b),
        .si    (si),
        .ci    (ci),
        .p     (p),
        .co    (co)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*N:0] expected_of(
        input logic [N-1:0] av,
        input logic [N-1:0] bv,
        input logic         s,
        input logic         c
    );
        logic [2*MAX_N:0] full;
        full = ref_product((MAX_N)'(av), (MAX_N)'(bv), s, c);
        return full[2*N:0];
    endfunction

    task automatic record(input string name, input bit ok,
                          input logic [2*N:0] got, input logic [2*N:0] want);
        check_count++;
        if (ok) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got {co,p}=%0d, expected %0d at %0t", name, got, want, $time);
        end
    endtask

    task automatic applyStimulus(input int av, input int bv, input int siv, input int civ);
        a  = av[N-1:0];
        b  = bv[N-1:0];
        si = siv[0];
        ci = civ[0];
    endtask

    task automatic checkOutput(input string name, input int exp_p, input int exp_co);
        logic [2*N:0] want;
        want = {exp_co[0], exp_p[2*N-1:0]};
        record(name, {co, p} === want, {co, p}, want);
    endtask

    // Expected output follows the last clean edge, or is forced to zero by reset.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) model_result = '0;
        else        model_result = expected_of(a, b, si, ci);
    end

    always @(negedge clk) begin
        if (compare_on) begin
            record("model", {co, p} === model_result, {co, p}, model_result);
        end
    end

    initial begin
        logic [2*N:0] res;

        rst_n = 1'b0;
        applyStimulus(15, 15, 0, 1);

        res = expected_of(4'd15, 4'd15, 1'b1, 1'b1);
        record("ref_pin_max", res === (2*N+1)'(227), res, (2*N+1)'(227));
        res = expected_of(4'd13, 4'd14, 1'b0, 1'b1);
        record("ref_pin_ci", res === (2*N+1)'(183), res, (2*N+1)'(183));
        res = expected_of(4'd0, 4'd0, 1'b1, 1'b1);
        record("ref_pin_zero", res === (2*N+1)'(2), res, (2*N+1)'(2));

        @(posedge clk);
        compare_on = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("reset_hold", 0, 0);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset_release", 226, 0);

        for (int i = 0; i < NUM_DIR; i++) begin
            applyStimulus(DIR_A[i], DIR_B[i], DIR_SI[i], DIR_CI[i]);
            @(negedge clk);
            checkOutput($sformatf("directed%0d", i), DIR_P[i], 0);
        end

        applyStimulus(37, 48, 0, 0);
        @(negedge clk);
        checkOutput("truncate", 0, 0);

        for (int i = 0; i < NUM_SEQ; i++) begin
            applyStimulus(SEQ_A[i], SEQ_B[i], SEQ_SI[i], 0);
            @(negedge clk);
            checkOutput($sformatf("back_to_back%0d", i), SEQ_P[i], 0);
        end

        applyStimulus(15, 15, 0, 0);
        @(posedge clk);
        #2;
        checkOutput("pre_async_reset", 225, 0);
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset", 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("after_async_reset", 225, 0);

        for (int v = 0; v < (1 << (2*N+2)); v++) begin
            applyStimulus(v[2*N+1:N+2], v[N+1:2], v[1], v[0]);
            @(negedge clk);
        end

        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, (1 << N) - 1), $urandom_range(0, (1 << N) - 1),
                          $urandom_range(0, 1), $urandom_range(0, 1));
            @(negedge clk);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/array_multiplier.md
Name: array_multiplier

Overview:
- Unsigned N×N carry-save array multiplier with two single-bit addend inputs, `si` and `ci`, injected at bit 0.
- The array is a combinational grid of full-adder cells; the 2N-bit product and carry-out are registered once.
- Used as a leaf arithmetic block in datapaths that need a small multiply-accumulate-by-one, e.g. rounding or increment.

Parameters:
- N, 4, operand width in bits (legal range 2..16); product width is 2N.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- a  input  N  unsigned multiplicand
- b  input  N  unsigned multiplier
- si  input  1  sum-in bit, added at weight 2^0 into the first array row
- ci  input  1  carry-in bit, added at weight 2^0 into the first array row
- p  output  2N  registered product bits, {co,p}[2N-1:0]
- co  output  1  registered carry-out, bit 2N of the extended result

Behaviour:
- Arithmetic: {co,p} = a*b + si + ci, all unsigned, computed at 2N+1 bits.
- The maximum result is (2^N-1)^2+2 < 2^2N, so `co` is always 0 for legal N. It is still a real carry out of the final ripple row, not tied off.
- Array structure:
  - AND-gate partial products pp[i][j] = a[j] & b[i].
  - N-1 carry-save rows of full-adder cells.
  - A final N-bit ripple adder merges sums and carries.
  - `si` and `ci` enter as the sum and carry inputs of the bit-0 cell of the first adder row.
- Operands are used as driven (N bits). Wider stimulus is truncated by the port width; no internal saturation.
- Timing:
  - The combinational result is captured into the p/co registers on every rising clk edge.
  - Latency is exactly 1 cycle from stable inputs to the output.
  - Throughput is one new operation per cycle. There is no handshake and no enable.
- Reset:
  - rst_n low asynchronously forces p = 0 and co = 0, regardless of clk.
  - Release is synchronous to clk; the first valid result appears on the first rising edge with rst_n high.
  - Reset asserted mid-stream discards the in-flight result; there is no residual state beyond the output registers.
- X/Z on inputs is not sanitised. Outputs reflect the array function only after a clean edge.

Decomposition:
- Shared package array_mult_pkg:
  - Default N constant.
  - A function `ref_product(a,b,si,ci)` that returns the 2N+1-bit expected result, for use by the verification model.
- One natural sub-module: mult_fa_cell, a full-adder cell (a, b, cin -> sum, cout).
- Instantiate mult_fa_cell N×N times via generate loops, covering both the carry-save rows and the final ripple row.
- The top level holds the partial-product ANDs and the output registers.

Test Plan:
- Reset: hold rst_n=0 with a=15, b=15, ci=1 and toggle clk -> p=0 and co=0 throughout. Release rst_n, then after one edge -> p=226, co=0.
- Basic products, one cycle each:
  - a=5, b=10, si=0, ci=0 -> p=50
  - a=15, b=3 -> p=45
  - a=5, b=2 -> p=10
  - a=4, b=8 -> p=32
  - co=0 in every case.
- Carry-in:
  - a=13, b=14, ci=1 -> p=183
  - a=10, b=11, ci=1 -> p=111
  - a=3, b=10, ci=1 -> p=31
  - a=15, b=15, ci=1 -> p=226
- Both addends and zero operands:
  - a=0, b=0, si=1, ci=1 -> p=2
  - a=5, b=0, si=0, ci=0 -> p=0
  - a=15, b=15, si=1, ci=1 -> p=227 (the maximum), co=0
- Truncation and pipelining:
  - Drive a=37, b=48 through the 4-bit ports -> they act as a=5, b=0 -> p=0.
  - Back-to-back operands on consecutive cycles -> each result appears exactly one cycle later, in order.
- Exhaustive/random: all 2^(2N+2) combinations for N=4, compared against `ref_product`. Assert rst_n asynchronously mid-stream -> outputs drop to 0 immediately, with no clock edge.
